alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, bytecode memory address width.
REQ-002 SHALL have parameter OP_W, default 6, ALU operation code width.
REQ-003 SHALL have parameter WDOG_MAX, default 255, maximum cycles to wait for alu_done.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run permission, sampled at instruction boundaries.
- mem_addr  out  ADDR_W  bytecode read address.
- mem_rd  out  1  read strobe; mem_rdata is valid the cycle after.
- mem_rdata  in  8  bytecode read data.
- alu_start  out  1  one-cycle ALU launch pulse.
- alu_op  out  OP_W  ALU operation.
- alu_a  out  8  operand A.
- alu_b  out  8  operand B.
- alu_result  in  8  ALU result.
- alu_done  in  1  ALU completion pulse.
- result  out  8  last captured ALU result.
- result_valid  out  1  one-cycle pulse on new result.
- running  out  1  sequencer executing.
- halted  out  1  HALT opcode reached (sticky).
- fault  out  1  error stop (sticky).

Function
REQ-005 SHALL implement FSM states IDLE, RD_OPC, RD_OPS, RD_A, RD_B, START, WAIT_DONE, HALT, FAULT.
REQ-006 SHALL spend exactly 2 cycles in each RD_* state: cycle 1 drives mem_rd=1 with mem_addr=pc; cycle 2 captures mem_rdata and increments pc.
REQ-007 SHALL leave IDLE for RD_OPC only when enable=1, with pc=0.
REQ-008 SHALL sample enable only in IDLE and in the first cycle of RD_OPC; with enable=0 it SHALL hold there with mem_rd=0, and it SHALL never stall mid-instruction.
REQ-009 SHALL decode the opcode as follows: 0x02 -> RD_OPS, RD_A, RD_B; 0x01 -> RD_OPS, RD_A, with alu_b=0; 0x00 -> NOP, returning to RD_OPC; 0xFF -> HALT; any other value -> FAULT.
REQ-010 SHALL load alu_op from the low OP_W bits of the RD_OPS byte; if any upper bit is set, it SHALL go to FAULT.
REQ-011 SHALL assert alu_start for exactly one cycle in START, holding alu_op, alu_a and alu_b stable from START until alu_done is sampled.
REQ-012 SHALL give a binary instruction 8 cycles from the first RD_OPC cycle to START, and a unary instruction 6 cycles.
REQ-013 SHALL sample alu_done only in WAIT_DONE; alu_done during START SHALL be ignored.
REQ-014 SHALL, on alu_done in WAIT_DONE, register alu_result into result, pulse result_valid on the next cycle, and enter RD_OPC on that same next cycle.
REQ-015 SHALL count WAIT_DONE cycles; on reaching WDOG_MAX without alu_done it SHALL enter FAULT.
REQ-016 SHALL enter FAULT when a fetch is required while pc = 2^ADDR_W-1 has already been consumed (no address wrap).
REQ-017 SHALL make HALT and FAULT terminal, exited only by reset; in both, mem_rd=0 and alu_start=0.
REQ-018 SHALL drive running=1 in all states except IDLE, HALT and FAULT; halted=1 only in HALT; fault=1 only in FAULT.

Reset
REQ-019 SHALL on reset immediately force: state IDLE, pc=0, watchdog=0, mem_addr=0, mem_rd=0, alu_start=0, alu_op=0, alu_a=0, alu_b=0, result=0, result_valid=0, running=0, halted=0, fault=0.
REQ-020 SHALL, on reset asserted mid-instruction or in WAIT_DONE, abandon the instruction and ignore any later alu_done until a new START.

Structure
REQ-021 SHALL place the state enum and opcode constants OPC_NOP=0x00, OPC_UNARY=0x01, OPC_BINARY=0x02, OPC_HALT=0xFF in a shared package mpb_pkg.
REQ-022 SHALL implement the watchdog as sub-module seq_watchdog (clear, count, expire output); all other logic SHALL be flat.

Verification
REQ-023 SHALL verify: program 02 05 0A 03 FF, ALU model a+b with done 2 cycles after start -> alu_start at cycle 9 with op=5, a=0x0A, b=0x03; result=0x0D with one result_valid pulse; halted=1; running=0.
REQ-024 SHALL verify: program 01 07 20 00 FF -> alu_b=0, one result_valid pulse, NOP consumed in 2 cycles, then halted.
REQ-025 SHALL verify: program 02 41 ... (op byte upper bits set), and separately opcode 0x33 -> fault=1, no alu_start, mem_rd=0 thereafter.
REQ-026 SHALL verify: ALU never returns alu_done -> fault=1 exactly WDOG_MAX cycles after entering WAIT_DONE.
REQ-027 SHALL verify: enable=0 at reset release -> stays IDLE; enable raised -> first mem_rd at addr 0 the next cycle; enable dropped mid-instruction -> instruction completes, then the sequencer holds at RD_OPC.
REQ-028 SHALL verify: reset pulsed during WAIT_DONE, with alu_done arriving 1 cycle later -> all outputs at reset values, result_valid stays 0, re-run from pc=0.

Source files
------------

// File: rtl/mpb_pkg.sv
// Shared definitions for the ALU sequencer: FSM state encoding, bytecode
// opcode values and a small state classification helper.
package mpb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_OPC,
    RD_OPS,
    RD_A,
    RD_B,
    START,
    WAIT_DONE,
    HALT,
    FAULT
  } seq_state_e;

  localparam logic [7:0] OPC_NOP    = 8'h00;
  localparam logic [7:0] OPC_UNARY  = 8'h01;
  localparam logic [7:0] OPC_BINARY = 8'h02;
  localparam logic [7:0] OPC_HALT   = 8'hFF;

  // True while the sequencer is executing a program.
  function automatic logic is_active(input seq_state_e s);
    return !(s inside {IDLE, HALT, FAULT});
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Cycle watchdog for the ALU wait phase.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the count from zero
//   count      : advance the count by one this cycle
//   expire     : registered; high during the MAX-th counted cycle
module seq_watchdog #(
  parameter int unsigned MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(MAX + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);

  // expire is computed from the value cnt takes next, so it is aligned with
  // the cycle in which cnt == MAX-1 (the last allowed waiting cycle).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      expire <= (MAX == 1);
    end else if (count) begin
      cnt    <= cnt_inc;
      expire <= (cnt_inc == CNT_W'(MAX - 1));
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Bytecode sequencer driving an external multi-cycle ALU.
// Fetches opcode / operation / operand bytes from a synchronous-read
// bytecode memory, launches the ALU, waits for completion under a watchdog
// and captures the result.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   enable              : run permission, honoured at instruction boundaries
//   mem_addr, mem_rd    : bytecode read address / strobe
//   mem_rdata           : bytecode byte, valid the cycle after mem_rd
//   alu_start           : one-cycle ALU launch pulse
//   alu_op, alu_a, alu_b: ALU operation and operands
//   alu_result, alu_done: ALU result and completion pulse
//   result, result_valid: captured result and its one-cycle valid pulse
//   running, halted, fault : status
module alu_sequencer
  import mpb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned OP_W     = 6,
  parameter int unsigned WDOG_MAX = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              alu_start,
  output logic [OP_W-1:0]   alu_op,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  input  logic [7:0]        alu_result,
  input  logic              alu_done,
  output logic [7:0]        result,
  output logic              result_valid,
  output logic              running,
  output logic              halted,
  output logic              fault
);

  // One extra pc bit marks "last address already consumed".
  localparam int unsigned PC_W = ADDR_W + 1;

  seq_state_e        state, state_n;
  logic              phase, phase_n;
  logic [PC_W-1:0]   pc, pc_n;
  logic              binary, binary_n;

  logic [ADDR_W-1:0] mem_addr_n;
  logic              mem_rd_n;
  logic              alu_start_n;
  logic [OP_W-1:0]   alu_op_n;
  logic [7:0]        alu_a_n;
  logic [7:0]        alu_b_n;
  logic [7:0]        result_n;
  logic              result_valid_n;
  logic              running_n;
  logic              halted_n;
  logic              fault_n;

  logic              fetch_req;
  logic              fetch_gated;
  seq_state_e        fetch_tgt;

  logic              wd_expire;

  seq_watchdog #(
    .MAX (WDOG_MAX)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != WAIT_DONE),
    .count  (state == WAIT_DONE),
    .expire (wd_expire)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= 1'b0;
      pc           <= '0;
      binary       <= 1'b0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      alu_start    <= 1'b0;
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      running      <= 1'b0;
      halted       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      pc           <= pc_n;
      binary       <= binary_n;
      mem_addr     <= mem_addr_n;
      mem_rd       <= mem_rd_n;
      alu_start    <= alu_start_n;
      alu_op       <= alu_op_n;
      alu_a        <= alu_a_n;
      alu_b        <= alu_b_n;
      result       <= result_n;
      result_valid <= result_valid_n;
      running      <= running_n;
      halted       <= halted_n;
      fault        <= fault_n;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_n        = state;
    phase_n        = 1'b0;
    pc_n           = pc;
    binary_n       = binary;
    alu_op_n       = alu_op;
    alu_a_n        = alu_a;
    alu_b_n        = alu_b;
    result_n       = result;
    result_valid_n = 1'b0;
    mem_rd_n       = 1'b0;
    fetch_req      = 1'b0;
    fetch_gated    = 1'b0;
    fetch_tgt      = RD_OPC;

    case (state)
      IDLE: begin
        if (enable) begin
          pc_n      = '0;
          fetch_req = 1'b1;
        end
      end

      RD_OPC: begin
        if (!phase) begin
          // mem_rd low here means the fetch is parked waiting for enable.
          if (mem_rd) begin
            phase_n = 1'b1;
          end else begin
            fetch_req   = 1'b1;
            fetch_gated = 1'b1;
          end
        end else begin
          pc_n = pc + PC_W'(1);
          case (mem_rdata)
            OPC_BINARY: begin
              binary_n  = 1'b1;
              fetch_req = 1'b1;
              fetch_tgt = RD_OPS;
            end
            OPC_UNARY: begin
              binary_n  = 1'b0;
              fetch_req = 1'b1;
              fetch_tgt = RD_OPS;
            end
            OPC_NOP: begin
              fetch_req   = 1'b1;
              fetch_gated = 1'b1;
            end
            OPC_HALT: state_n = HALT;
            default:  state_n = FAULT;
          endcase
        end
      end

      RD_OPS: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          pc_n = pc + PC_W'(1);
          if ((mem_rdata >> OP_W) != 8'd0) begin
            state_n = FAULT;
          end else begin
            alu_op_n  = OP_W'(mem_rdata);
            fetch_req = 1'b1;
            fetch_tgt = RD_A;
          end
        end
      end

      RD_A: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          pc_n    = pc + PC_W'(1);
          alu_a_n = mem_rdata;
          if (binary) begin
            fetch_req = 1'b1;
            fetch_tgt = RD_B;
          end else begin
            alu_b_n = 8'd0;
            state_n = START;
          end
        end
      end

      RD_B: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          pc_n    = pc + PC_W'(1);
          alu_b_n = mem_rdata;
          state_n = START;
        end
      end

      START: state_n = WAIT_DONE;

      WAIT_DONE: begin
        if (alu_done) begin
          result_n       = alu_result;
          result_valid_n = 1'b1;
          fetch_req      = 1'b1;
          fetch_gated    = 1'b1;
        end else if (wd_expire) begin
          state_n = FAULT;
        end
      end

      HALT:    state_n = HALT;
      FAULT:   state_n = FAULT;
      default: state_n = FAULT;
    endcase

    // Common fetch launch: optional enable gate, then end-of-memory check.
    if (fetch_req) begin
      if (fetch_gated && !enable) begin
        state_n = fetch_tgt;
      end else if (pc_n[ADDR_W]) begin
        state_n = FAULT;
      end else begin
        state_n  = fetch_tgt;
        mem_rd_n = 1'b1;
      end
    end

    mem_addr_n  = ADDR_W'(pc_n);
    alu_start_n = (state_n == START);
    running_n   = is_active(state_n);
    halted_n    = (state_n == HALT);
    fault_n     = (state_n == FAULT);
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table of whole-program vectors plus
// hand-written sequences for watchdog, enable gating and mid-wait reset.
module tb_alu_sequencer;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned WDOG_MAX = 16;
  localparam int unsigned MEM_N    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata = 8'h00;
  logic              alu_start;
  logic [OP_W-1:0]   alu_op;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [7:0]        alu_result = 8'h00;
  logic              alu_done = 1'b0;
  logic [7:0]        result;
  logic              result_valid;
  logic              running;
  logic              halted;
  logic              fault;

  alu_sequencer #(
    .ADDR_W   (ADDR_W),
    .OP_W     (OP_W),
    .WDOG_MAX (WDOG_MAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_rdata    (mem_rdata),
    .alu_start    (alu_start),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_done     (alu_done),
    .result       (result),
    .result_valid (result_valid),
    .running      (running),
    .halted       (halted),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  // Bytecode memory: registered read.
  logic [7:0] mem [MEM_N];
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // ALU model: a+b, done pulse alu_lat cycles after the start cycle.
  int         alu_lat = 2;
  bit         alu_on = 1'b1;
  int         alu_cnt = 0;
  logic [7:0] lat_a = 8'h00;
  logic [7:0] lat_b = 8'h00;
  always @(negedge clk) begin
    alu_done = 1'b0;
    if (alu_cnt > 0) begin
      alu_cnt = alu_cnt - 1;
      if (alu_cnt == 0) begin
        alu_done   = 1'b1;
        alu_result = lat_a + lat_b;
      end
    end
    if (alu_start && alu_on) begin
      alu_cnt = alu_lat;
      lat_a   = alu_a;
      lat_b   = alu_b;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Unused memory is filled with HALT so a runaway program stops.
  task automatic load_prog(input int len, input logic [127:0] p);
    for (int i = 0; i < int'(MEM_N); i++)
      mem[i] = (i < len) ? p[8*i +: 8] : 8'hFF;
  endtask

  // Hold reset long enough for any pending ALU done to drain; the next tick
  // after return is cycle 1 when en=1.
  task automatic start_run(input bit en);
    reset  = 1'b1;
    enable = 1'b0;
    repeat (4) tick();
    reset  = 1'b0;
    enable = en;
    cyc    = 0;
  endtask

  typedef struct {
    int         len;
    logic [127:0] prog;   // byte i at prog[8*i +: 8]
    int         stop;     // cycle halted/fault first seen
    logic       halt;
    logic       flt;
    int         starts;
    int         first;    // cycle of first alu_start
    logic [7:0] op;       // last launched op/a/b
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    int         rv;
  } vec_t;

  function automatic vec_t mk(input int len, input logic [127:0] p, input int stop,
                              input logic h, input logic f, input int starts, input int first,
                              input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] res, input int rv);
    vec_t v;
    v.len = len; v.prog = p; v.stop = stop; v.halt = h; v.flt = f;
    v.starts = starts; v.first = first; v.op = op; v.a = a; v.b = b;
    v.res = res; v.rv = rv;
    return v;
  endfunction

  localparam int NV = 8;
  vec_t vecs [NV];

  int         stop_c, nst, first_c, nrv, fcyc;
  logic [7:0] lop, la, lb;
  bit         ok;

  initial begin
    // Programs written last byte first (byte 0 in the low bits).
    vecs[0] = mk(5,  40'hFF030A0502,          14, 1, 0, 1, 9, 8'h05, 8'h0A, 8'h03, 8'h0D, 1);
    vecs[1] = mk(5,  40'hFF00200701,          14, 1, 0, 1, 7, 8'h07, 8'h20, 8'h00, 8'h20, 1);
    vecs[2] = mk(2,  16'h4102,                 5, 0, 1, 0, -1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    vecs[3] = mk(1,  8'h33,                    3, 0, 1, 0, -1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    vecs[4] = mk(3,  24'hFF0000,               7, 1, 0, 0, -1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    vecs[5] = mk(8,  64'hFF02010101FF3F02,    23, 1, 0, 2, 9, 8'h01, 8'h02, 8'h00, 8'h02, 2);
    vecs[6] = mk(2,  16'hC001,                 5, 0, 1, 0, -1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    vecs[7] = mk(16, 128'h0,                  33, 0, 1, 0, -1, 8'h00, 8'h00, 8'h00, 8'h00, 0);

    // Reset state.
    load_prog(0, 128'h0);
    reset = 1'b1;
    repeat (2) tick();
    chk("reset_ctl", {mem_rd, alu_start, result_valid, running, halted, fault}, 0);
    chk("reset_data", {mem_addr, alu_op, alu_a, alu_b, result}, 0);

    // Table-driven whole programs.
    for (int v = 0; v < NV; v++) begin
      load_prog(vecs[v].len, vecs[v].prog);
      alu_on = 1'b1; alu_lat = 2;
      start_run(1'b1);
      stop_c = -1; nst = 0; first_c = -1; nrv = 0; lop = 0; la = 0; lb = 0;
      for (int k = 0; k < 100; k++) begin
        tick();
        if (alu_start) begin
          nst++;
          if (first_c < 0) first_c = cyc;
          lop = 8'(alu_op); la = alu_a; lb = alu_b;
        end
        if (result_valid) nrv++;
        if (halted || fault) begin
          stop_c = cyc;
          break;
        end
      end
      chk($sformatf("v%0d_stop_cycle", v), stop_c, vecs[v].stop);
      chk($sformatf("v%0d_halted", v), halted, vecs[v].halt);
      chk($sformatf("v%0d_fault", v), fault, vecs[v].flt);
      chk($sformatf("v%0d_starts", v), nst, vecs[v].starts);
      chk($sformatf("v%0d_first_start", v), first_c, vecs[v].first);
      chk($sformatf("v%0d_result", v), result, vecs[v].res);
      chk($sformatf("v%0d_rv_pulses", v), nrv, vecs[v].rv);
      if (vecs[v].starts > 0) begin
        chk($sformatf("v%0d_op_a_b", v), {lop, la, lb}, {vecs[v].op, vecs[v].a, vecs[v].b});
      end
      ok = 1'b1;
      repeat (3) begin
        tick();
        if (mem_rd || alu_start || running || result_valid ||
            halted != vecs[v].halt || fault != vecs[v].flt) ok = 1'b0;
      end
      chk($sformatf("v%0d_terminal_quiet", v), ok, 1);
    end

    // Watchdog: ALU never answers; WAIT_DONE entered at cycle 10.
    load_prog(5, 40'hFF030A0502);
    alu_on = 1'b0;
    start_run(1'b1);
    fcyc = -1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (fault) begin
        fcyc = cyc;
        break;
      end
    end
    chk("wdog_fault_cycle", fcyc, 10 + WDOG_MAX);
    tick();
    chk("wdog_terminal", {mem_rd, alu_start, running, fault}, 4'b0001);
    alu_on = 1'b1;

    // Enable gating.
    load_prog(5, 40'hFF030A0502);
    alu_lat = 2;
    start_run(1'b0);
    ok = 1'b1;
    repeat (4) begin
      tick();
      if (running || mem_rd || halted || fault) ok = 1'b0;
    end
    chk("en_idle_hold", ok, 1);
    enable = 1'b1;
    cyc = 0;
    tick();
    chk("en_first_read", {mem_rd, mem_addr}, {1'b1, 4'h0});
    repeat (3) tick();
    enable = 1'b0;                         // dropped during RD_OPS/RD_A
    while (cyc < 12) tick();
    chk("en_drop_rv", result_valid, 1);
    chk("en_drop_result", result, 8'h0D);
    ok = 1'b1;
    repeat (4) begin
      if (mem_rd || !running || halted || fault) ok = 1'b0;
      tick();
    end
    chk("en_held_rdopc", ok, 1);
    enable = 1'b1;
    tick();
    chk("en_resume_read", {mem_rd, mem_addr}, {1'b1, 4'h4});
    repeat (2) tick();
    chk("en_resume_halt", {halted, running}, 2'b10);

    // Reset during WAIT_DONE with a late alu_done.
    load_prog(5, 40'hFF030A0502);
    alu_lat = 3;
    start_run(1'b1);
    while (cyc < 10) tick();
    chk("rst_in_wait", {running, alu_start, mem_rd}, 3'b100);
    reset = 1'b1;
    #1;
    chk("rst_async_ctl", {mem_rd, alu_start, result_valid, running, halted, fault}, 0);
    chk("rst_async_data", {mem_addr, alu_op, alu_a, alu_b, result}, 0);
    tick();
    reset  = 1'b0;
    enable = 1'b0;
    ok = 1'b1;
    repeat (4) begin
      tick();
      if (result_valid || running || result != 8'h00) ok = 1'b0;
    end
    chk("rst_stale_done_ignored", ok, 1);
    enable = 1'b1;
    cyc = 0;
    nrv = 0;
    tick();
    chk("rst_rerun_addr0", {mem_rd, mem_addr}, {1'b1, 4'h0});
    for (int k = 0; k < 60; k++) begin
      if (result_valid) nrv++;
      if (halted || fault) break;
      tick();
    end
    chk("rst_rerun_end", {halted, fault, result}, {1'b1, 1'b0, 8'h0D});
    chk("rst_rerun_rv", nrv, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
